// File: rtl/chip8_fetch_unit.sv
// -----------------------------------------------------------------------------
// chip8_fetch_unit
// Instruction-fetch sequencer for the CHIP-8 CPU. It owns the program counter
// and reads each 2-byte big-endian opcode from byte-wide RAM, which has a
// 1-cycle read latency. The opcode is handed to execute over a valid/ready
// handshake. The next-PC decision (sequential, skip or jump) returned by
// execute is applied when the handshake completes.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   run            permits the start of a new fetch
//   mem_busy       execute owns RAM this cycle; no read strobe may issue
//   mem_rd         RAM read strobe (combinational)
//   mem_addr       RAM read address (combinational, 0 when not reading)
//   mem_rdata      RAM read data, valid the cycle after mem_rd
//   opcode         fetched instruction {hi_byte, lo_byte}
//   opcode_valid   opcode is complete and stable
//   opcode_ready   execute finished the instruction (handshake)
//   pc_load        jump/call/return to pc_load_value at handshake
//   pc_load_value  jump target
//   skip           skip the next instruction at handshake
//   pc             address of the current / being-fetched instruction
// -----------------------------------------------------------------------------
module chip8_fetch_unit #(
    parameter logic [11:0] PC_RESET = 12'h200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_busy,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] opcode,
    output logic        opcode_valid,
    input  logic        opcode_ready,
    input  logic        pc_load,
    input  logic [11:0] pc_load_value,
    input  logic        skip,
    output logic [11:0] pc
);

    typedef enum logic [2:0] {
        S_HI_REQ,
        S_HI_WAIT,
        S_LO_REQ,
        S_LO_WAIT,
        S_VALID
    } state_t;

    state_t      state_q;
    logic [11:0] pc_q;
    logic [15:0] opcode_q;
    logic        valid_q;

    logic [11:0] pc_plus1;
    logic [11:0] pc_next_d;

    // 12-bit additions wrap naturally modulo 4096.
    assign pc_plus1 = pc_q + 12'd1;

    // Next PC taken at handshake; a jump overrides a skip.
    always_comb begin
        pc_next_d = pc_q + 12'd2;
        if (pc_load) begin
            pc_next_d = pc_load_value;
        end else if (skip) begin
            pc_next_d = pc_q + 12'd4;
        end
    end

    // Read strobe. run only gates the start of a fetch; once the high byte
    // has been requested, the low byte is fetched regardless of run.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = 12'h000;
        case (state_q)
            S_HI_REQ: begin
                if (run && !mem_busy) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_q;
                end
            end
            S_LO_REQ: begin
                if (!mem_busy) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_plus1;
                end
            end
            default: begin
                mem_rd   = 1'b0;
                mem_addr = 12'h000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_HI_REQ;
            pc_q     <= PC_RESET;
            opcode_q <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_HI_REQ: begin
                    if (run && !mem_busy) begin
                        state_q <= S_HI_WAIT;
                    end
                end
                S_HI_WAIT: begin
                    // Data is captured even if mem_busy is now high: the read
                    // was issued last cycle, so this byte belongs to us.
                    opcode_q[15:8] <= mem_rdata;
                    state_q        <= S_LO_REQ;
                end
                S_LO_REQ: begin
                    if (!mem_busy) begin
                        state_q <= S_LO_WAIT;
                    end
                end
                S_LO_WAIT: begin
                    opcode_q[7:0] <= mem_rdata;
                    valid_q       <= 1'b1;
                    state_q       <= S_VALID;
                end
                S_VALID: begin
                    if (opcode_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_next_d;
                        state_q <= S_HI_REQ;
                    end
                end
                default: begin
                    state_q <= S_HI_REQ;
                end
            endcase
        end
    end

    assign opcode       = opcode_q;
    assign opcode_valid = valid_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_chip8_fetch_unit
// Bench for chip8_fetch_unit. A byte RAM with 1-cycle read latency serves the
// DUT. A transaction-level model (expected PC, when each byte read may issue,
// when the opcode becomes valid) is checked every cycle on the falling edge.
// Directed scenarios pin the model with literal expectations, then random
// run/busy/ready/load/skip/reset stimulus follows.
// -----------------------------------------------------------------------------
module tb_chip8_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_busy;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic        pc_load;
    logic [11:0] pc_load_value;
    logic        skip;
    logic [11:0] pc;

    logic [7:0]  ram [4096];

    int n_cmp = 0;
    int n_bad = 0;
    int n_hs  = 0;

    always #5 clk = ~clk;

    chip8_fetch_unit #(.PC_RESET(12'h200)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .mem_busy      (mem_busy),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .opcode        (opcode),
        .opcode_valid  (opcode_valid),
        .opcode_ready  (opcode_ready),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .skip          (skip),
        .pc            (pc)
    );

    // RAM: registered read; outside read cycles the bus carries junk so that a
    // stray capture would show up as a wrong opcode.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
        else        mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare process ----------------
    logic [11:0] m_pc;
    logic [11:0] m_pc1;
    logic        m_valid;
    logic        started = 1'b0;
    logic        opc_zero;
    int          hi_at, lo_at, cyc = 0;
    logic        hi_phase, lo_phase, e_rd;
    logic [11:0] e_addr;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            m_pc1    = m_pc + 12'd1;
            hi_phase = 1'b0;
            lo_phase = 1'b0;
            e_rd     = 1'b0;
            e_addr   = 12'h000;
            if (started) begin
                hi_phase = !m_valid && (hi_at < 0);
                lo_phase = (hi_at >= 0) && (lo_at < 0) && (cyc >= hi_at + 2);
                if (hi_phase) begin
                    e_rd   = run && !mem_busy;
                    e_addr = m_pc;
                end else if (lo_phase) begin
                    e_rd   = !mem_busy;
                    e_addr = m_pc1;
                end
                chk("mem_rd", {15'd0, mem_rd}, {15'd0, e_rd});
                if (e_rd && mem_rd) chk("mem_addr", {4'd0, mem_addr}, {4'd0, e_addr});
                chk("opcode_valid", {15'd0, opcode_valid}, {15'd0, m_valid});
                chk("pc", {4'd0, pc}, {4'd0, m_pc});
                if (m_valid)       chk("opcode", opcode, {ram[m_pc], ram[m_pc1]});
                else if (opc_zero) chk("opcode_reset", opcode, 16'h0000);
            end
            // advance the model to what the next rising edge produces
            if (reset) begin
                started  = 1'b1;
                m_pc     = 12'h200;
                hi_at    = -1;
                lo_at    = -1;
                m_valid  = 1'b0;
                opc_zero = 1'b1;
            end else if (started) begin
                if (m_valid) begin
                    if (opcode_ready) begin
                        n_hs++;
                        if (pc_load)   m_pc = pc_load_value;
                        else if (skip) m_pc = m_pc + 12'd4;
                        else           m_pc = m_pc + 12'd2;
                        m_valid = 1'b0;
                        hi_at   = -1;
                        lo_at   = -1;
                    end
                end else if (hi_phase && e_rd) begin
                    hi_at    = cyc;
                    opc_zero = 1'b0;
                end else if (lo_phase && e_rd) begin
                    lo_at = cyc;
                end else if (lo_at >= 0 && cyc == lo_at + 1) begin
                    m_valid = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!opcode_valid && n < 40) begin
            step();
            n++;
        end
        if (!opcode_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid: got timeout expected opcode_valid within 40 cycles");
        end
    endtask

    task automatic handshake(input logic ld, input logic [11:0] val, input logic sk);
        opcode_ready  = 1'b1;
        pc_load       = ld;
        pc_load_value = val;
        skip          = sk;
        step();
        opcode_ready  = 1'b0;
        pc_load       = 1'b0;
        skip          = 1'b0;
    endtask

    int n;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h200] = 8'h00; ram[12'h201] = 8'hE0;
        ram[12'h202] = 8'h12; ram[12'h203] = 8'h34;
        ram[12'h206] = 8'h9A; ram[12'h207] = 8'hBC;
        ram[12'hFFF] = 8'hAB; ram[12'h000] = 8'hCD;
        ram[12'h300] = 8'h5A; ram[12'h301] = 8'hA5;
        ram[12'h400] = 8'h11; ram[12'h401] = 8'h22;
        ram[12'h402] = 8'h33; ram[12'h403] = 8'h44;

        reset = 1'b1; run = 1'b0; mem_busy = 1'b0; opcode_ready = 1'b0;
        pc_load = 1'b0; pc_load_value = 12'h000; skip = 1'b0;
        step();
        step();
        chk("reset_valid", {15'd0, opcode_valid}, 16'h0000);
        chk("reset_pc", {4'd0, pc}, 16'h0200);
        chk("reset_opcode", opcode, 16'h0000);
        reset = 1'b0;

        // run held low: model checks that no read issues
        repeat (5) step();
        run = 1'b1;
        wait_valid(n);
        chk("t1_latency", 16'(n), 16'd4);
        chk("t1_opcode", opcode, 16'h00E0);
        chk("t1_pc", {4'd0, pc}, 16'h0200);
        $display("T1 opcode=%h pc=%h latency=%0d", opcode, pc, n);

        handshake(1'b0, 12'h000, 1'b0);
        wait_valid(n);
        chk("t2_latency", 16'(n), 16'd4);
        chk("t2_opcode", opcode, 16'h1234);
        chk("t2_pc", {4'd0, pc}, 16'h0202);
        $display("T2a opcode=%h pc=%h", opcode, pc);

        handshake(1'b0, 12'h000, 1'b1);
        wait_valid(n);
        chk("t2_skip_pc", {4'd0, pc}, 16'h0206);
        chk("t2_skip_opcode", opcode, 16'h9ABC);
        $display("T2b opcode=%h pc=%h", opcode, pc);

        handshake(1'b1, 12'hFFF, 1'b1);
        wait_valid(n);
        chk("t3_pc", {4'd0, pc}, 16'h0FFF);
        chk("t3_opcode", opcode, 16'hABCD);
        $display("T3 opcode=%h pc=%h", opcode, pc);

        // busy for three cycles in the low-byte request stage
        handshake(1'b1, 12'h300, 1'b0);
        step();
        step();
        mem_busy = 1'b1;
        step(); step(); step();
        mem_busy = 1'b0;
        wait_valid(n);
        chk("t4_tail_latency", 16'(n), 16'd2);
        chk("t4_opcode", opcode, 16'h5AA5);
        $display("T4 opcode=%h pc=%h", opcode, pc);

        // run dropped after the fetch started
        handshake(1'b1, 12'h400, 1'b0);
        step();
        run = 1'b0;
        wait_valid(n);
        chk("t5_tail_latency", 16'(n), 16'd3);
        chk("t5_opcode", opcode, 16'h1122);
        handshake(1'b0, 12'h000, 1'b0);
        repeat (3) step();
        run = 1'b1;
        wait_valid(n);
        chk("t5_restart_latency", 16'(n), 16'd4);
        chk("t5_restart_opcode", opcode, 16'h3344);
        $display("T5 opcode=%h pc=%h", opcode, pc);

        // reset while the low byte is in flight
        handshake(1'b0, 12'h000, 1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_valid", {15'd0, opcode_valid}, 16'h0000);
        chk("t6_opcode", opcode, 16'h0000);
        chk("t6_pc", {4'd0, pc}, 16'h0200);
        wait_valid(n);
        chk("t6_latency", 16'(n), 16'd4);
        chk("t6_opcode_refetch", opcode, 16'h00E0);
        $display("T6 opcode=%h pc=%h", opcode, pc);

        // random phase, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            mem_busy      = ($urandom_range(0, 9) < 3);
            run           = ($urandom_range(0, 9) < 8);
            opcode_ready  = ($urandom_range(0, 9) < 4);
            pc_load       = ($urandom_range(0, 3) == 0);
            pc_load_value = 12'($urandom);
            skip          = ($urandom_range(0, 2) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; opcode_ready = 1'b0; mem_busy = 1'b0;
        step();
        n_cmp++;
        if (n_hs < 50) begin
            n_bad++;
            $display("FAIL handshake_activity: got %0d expected at least 50", n_hs);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
